// File: rtl/stage_3_butterfly.sv
// Radix-2 butterfly stage of the 1024-point, 32-lane NTT: 16 pairs per beat,
// per-beat twiddles from a 512-entry table, fixed 3-cycle modular pipeline.
module stage_3_butterfly #(
  parameter int unsigned DATA_WIDTH_PER_INPUT = 32,
  parameter int unsigned INPUT_PER_CYCLE = 32,
  parameter logic [DATA_WIDTH_PER_INPUT-1:0] MODULUS = 32'd4293918721,
  parameter int unsigned BEATS_PER_FRAME = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sync,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,  inData_1,  inData_2,  inData_3,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_4,  inData_5,  inData_6,  inData_7,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_8,  inData_9,  inData_10, inData_11,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_12, inData_13, inData_14, inData_15,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_16, inData_17, inData_18, inData_19,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_20, inData_21, inData_22, inData_23,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_24, inData_25, inData_26, inData_27,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_28, inData_29, inData_30, inData_31,
  input  logic tw_wr_en,
  input  logic [8:0] tw_wr_addr,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] tw_wr_data,
  output logic out_valid,
  output logic out_last,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,  outData_1,  outData_2,  outData_3,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_4,  outData_5,  outData_6,  outData_7,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_8,  outData_9,  outData_10, outData_11,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_12, outData_13, outData_14, outData_15,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_16, outData_17, outData_18, outData_19,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_20, outData_21, outData_22, outData_23,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_24, outData_25, outData_26, outData_27,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_28, outData_29, outData_30, outData_31
);
  localparam int unsigned W  = DATA_WIDTH_PER_INPUT;
  localparam int unsigned W2 = 2 * DATA_WIDTH_PER_INPUT;
  localparam int unsigned W1 = DATA_WIDTH_PER_INPUT + 1;
  localparam int unsigned NP = INPUT_PER_CYCLE / 2;
  localparam logic [W2-1:0] Q2 = W2'(MODULUS);
  localparam logic [W1-1:0] Q1 = W1'(MODULUS);

  logic [W-1:0] in_lane  [INPUT_PER_CYCLE];
  logic [W-1:0] out_lane [INPUT_PER_CYCLE];
  logic [W-1:0] res      [INPUT_PER_CYCLE];
  logic [W-1:0] tw_mem   [512];
  logic [W-1:0] tw_rd    [NP];

  logic [4:0] beat_cnt, beat_used;
  logic in_last;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic [W-1:0]  s1_a [NP];
  logic [W2-1:0] s1_prod [NP];
  logic [W-1:0]  s2_a [NP];
  logic [W-1:0]  s2_t [NP];
  logic [W1-1:0] sum [NP];

  assign in_lane[0]  = inData_0;  assign in_lane[1]  = inData_1;
  assign in_lane[2]  = inData_2;  assign in_lane[3]  = inData_3;
  assign in_lane[4]  = inData_4;  assign in_lane[5]  = inData_5;
  assign in_lane[6]  = inData_6;  assign in_lane[7]  = inData_7;
  assign in_lane[8]  = inData_8;  assign in_lane[9]  = inData_9;
  assign in_lane[10] = inData_10; assign in_lane[11] = inData_11;
  assign in_lane[12] = inData_12; assign in_lane[13] = inData_13;
  assign in_lane[14] = inData_14; assign in_lane[15] = inData_15;
  assign in_lane[16] = inData_16; assign in_lane[17] = inData_17;
  assign in_lane[18] = inData_18; assign in_lane[19] = inData_19;
  assign in_lane[20] = inData_20; assign in_lane[21] = inData_21;
  assign in_lane[22] = inData_22; assign in_lane[23] = inData_23;
  assign in_lane[24] = inData_24; assign in_lane[25] = inData_25;
  assign in_lane[26] = inData_26; assign in_lane[27] = inData_27;
  assign in_lane[28] = inData_28; assign in_lane[29] = inData_29;
  assign in_lane[30] = inData_30; assign in_lane[31] = inData_31;

  assign outData_0  = out_lane[0];  assign outData_1  = out_lane[1];
  assign outData_2  = out_lane[2];  assign outData_3  = out_lane[3];
  assign outData_4  = out_lane[4];  assign outData_5  = out_lane[5];
  assign outData_6  = out_lane[6];  assign outData_7  = out_lane[7];
  assign outData_8  = out_lane[8];  assign outData_9  = out_lane[9];
  assign outData_10 = out_lane[10]; assign outData_11 = out_lane[11];
  assign outData_12 = out_lane[12]; assign outData_13 = out_lane[13];
  assign outData_14 = out_lane[14]; assign outData_15 = out_lane[15];
  assign outData_16 = out_lane[16]; assign outData_17 = out_lane[17];
  assign outData_18 = out_lane[18]; assign outData_19 = out_lane[19];
  assign outData_20 = out_lane[20]; assign outData_21 = out_lane[21];
  assign outData_22 = out_lane[22]; assign outData_23 = out_lane[23];
  assign outData_24 = out_lane[24]; assign outData_25 = out_lane[25];
  assign outData_26 = out_lane[26]; assign outData_27 = out_lane[27];
  assign outData_28 = out_lane[28]; assign outData_29 = out_lane[29];
  assign outData_30 = out_lane[30]; assign outData_31 = out_lane[31];

  // in_sync forces row 0 for the current beat, realigning any partial frame
  assign beat_used = (in_valid && in_sync) ? '0 : beat_cnt;
  assign in_last   = in_valid && (beat_used == 5'(BEATS_PER_FRAME - 1));

  // Combinational read: a same-cycle write is seen only from the next cycle
  always_comb begin
    for (int unsigned k = 0; k < NP; k++) tw_rd[k] = tw_mem[{beat_used, 4'(k)}];
  end

  always_ff @(posedge clk) begin
    if (tw_wr_en) tw_mem[tw_wr_addr] <= tw_wr_data;
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NP; k++) begin
      s1_a[k]    <= in_lane[2*k];
      s1_prod[k] <= W2'(tw_rd[k]) * W2'(in_lane[2*k+1]);
      s2_a[k]    <= s1_a[k];
      s2_t[k]    <= W'(s1_prod[k] % Q2);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NP; k++) begin
      sum[k] = {1'b0, s2_a[k]} + {1'b0, s2_t[k]};
      res[2*k] = (sum[k] >= Q1) ? W'(sum[k] - Q1) : W'(sum[k]);
      res[2*k+1] = (s2_a[k] < s2_t[k]) ? W'({1'b0, s2_a[k]} + Q1 - {1'b0, s2_t[k]})
                                       : (s2_a[k] - s2_t[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int unsigned i = 0; i < INPUT_PER_CYCLE; i++) out_lane[i] <= '0;
    end else begin
      if (in_valid) beat_cnt <= beat_used + 5'd1;
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      out_last  <= s2_last;
      if (s2_valid) begin
        for (int unsigned i = 0; i < INPUT_PER_CYCLE; i++) out_lane[i] <= res[i];
      end
    end
  end
endmodule

// File: tb/tb_stage_3_butterfly.sv
// Randomized scoreboard bench for stage_3_butterfly against a modular-arithmetic model.
module tb_stage_3_butterfly;
  localparam logic [31:0] Q = 32'd4293918721;
  localparam longint unsigned Q64 = 64'd4293918721;

  typedef logic [31:0][31:0] lanes_t;
  typedef struct packed { logic last; lanes_t d; } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sync, tw_wr_en;
  logic [8:0] tw_wr_addr;
  logic [31:0] tw_wr_data;
  lanes_t in_d;
  logic out_valid, out_last;
  logic [31:0] out_d [32];

  beat_t exp_q[$];
  logic [31:0] m_tw [512];
  int unsigned m_pos;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stage_3_butterfly #(.DATA_WIDTH_PER_INPUT(32), .INPUT_PER_CYCLE(32),
                      .MODULUS(32'd4293918721), .BEATS_PER_FRAME(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .inData_0(in_d[0]),   .inData_1(in_d[1]),   .inData_2(in_d[2]),   .inData_3(in_d[3]),
    .inData_4(in_d[4]),   .inData_5(in_d[5]),   .inData_6(in_d[6]),   .inData_7(in_d[7]),
    .inData_8(in_d[8]),   .inData_9(in_d[9]),   .inData_10(in_d[10]), .inData_11(in_d[11]),
    .inData_12(in_d[12]), .inData_13(in_d[13]), .inData_14(in_d[14]), .inData_15(in_d[15]),
    .inData_16(in_d[16]), .inData_17(in_d[17]), .inData_18(in_d[18]), .inData_19(in_d[19]),
    .inData_20(in_d[20]), .inData_21(in_d[21]), .inData_22(in_d[22]), .inData_23(in_d[23]),
    .inData_24(in_d[24]), .inData_25(in_d[25]), .inData_26(in_d[26]), .inData_27(in_d[27]),
    .inData_28(in_d[28]), .inData_29(in_d[29]), .inData_30(in_d[30]), .inData_31(in_d[31]),
    .tw_wr_en(tw_wr_en), .tw_wr_addr(tw_wr_addr), .tw_wr_data(tw_wr_data),
    .out_valid(out_valid), .out_last(out_last),
    .outData_0(out_d[0]),   .outData_1(out_d[1]),   .outData_2(out_d[2]),   .outData_3(out_d[3]),
    .outData_4(out_d[4]),   .outData_5(out_d[5]),   .outData_6(out_d[6]),   .outData_7(out_d[7]),
    .outData_8(out_d[8]),   .outData_9(out_d[9]),   .outData_10(out_d[10]), .outData_11(out_d[11]),
    .outData_12(out_d[12]), .outData_13(out_d[13]), .outData_14(out_d[14]), .outData_15(out_d[15]),
    .outData_16(out_d[16]), .outData_17(out_d[17]), .outData_18(out_d[18]), .outData_19(out_d[19]),
    .outData_20(out_d[20]), .outData_21(out_d[21]), .outData_22(out_d[22]), .outData_23(out_d[23]),
    .outData_24(out_d[24]), .outData_25(out_d[25]), .outData_26(out_d[26]), .outData_27(out_d[27]),
    .outData_28(out_d[28]), .outData_29(out_d[29]), .outData_30(out_d[30]), .outData_31(out_d[31])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, got, got, want, want);
    end
  endtask

  // First mismatching lane against a full expected beat (all lanes must match)
  task automatic check_lanes(input string name, input lanes_t want);
    int bad = -1;
    for (int i = 31; i >= 0; i--) if (out_d[i] !== want[i]) bad = i;
    if (bad < 0) check(name, out_d[0], want[0]);
    else check($sformatf("%s lane %0d", name, bad), out_d[bad], want[bad]);
  endtask

  // Reference: pair k combines a, b with table row (frame position, k)
  task automatic model_beat(input logic sync, input lanes_t a_in);
    beat_t e;
    longint unsigned a64, w64, b64, t64;
    if (sync) m_pos = 0;
    e.last = (m_pos == 31);
    for (int k = 0; k < 16; k++) begin
      a64 = 64'(a_in[2*k]);
      b64 = 64'(a_in[2*k+1]);
      w64 = 64'(m_tw[m_pos * 16 + k]);
      t64 = (w64 * b64) % Q64;
      e.d[2*k]   = 32'((a64 + t64) % Q64);
      e.d[2*k+1] = 32'((a64 + Q64 - t64) % Q64);
    end
    exp_q.push_back(e);
    m_pos = (m_pos + 1) % 32;
  endtask

  task automatic step(input logic v, input logic s, input lanes_t a_in,
                      input logic we, input int unsigned wa, input logic [31:0] wd);
    in_valid = v; in_sync = s; in_d = a_in;
    tw_wr_en = we; tw_wr_addr = 9'(wa); tw_wr_data = wd;
    if (v) model_beat(s, a_in);
    if (we) m_tw[wa] = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sync = 1'b0; tw_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 0, '0);
  endtask

  function automatic lanes_t pairs(input logic [31:0] a, input logic [31:0] b);
    lanes_t l;
    for (int k = 0; k < 16; k++) begin l[2*k] = a; l[2*k+1] = b; end
    return l;
  endfunction

  function automatic lanes_t rand_lanes();
    lanes_t l;
    for (int i = 0; i < 32; i++) l[i] = $urandom_range(32'hFFF00000, 0);
    return l;
  endfunction

  // mode 0: all ones, 1: beat*16+k+1, 2: random below Q
  task automatic load_tw(input int mode);
    for (int unsigned a = 0; a < 512; a++)
      step(1'b0, 1'b0, '0, 1'b1, a,
           (mode == 0) ? 32'd1 : (mode == 1) ? 32'(a + 1) : $urandom_range(32'hFFF00000, 0));
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_last", 32'(out_last), 32'(e.last));
          check_lanes("outData", e.d);
        end
      end
    end
  end

  initial begin : stim
    lanes_t zero;
    zero = '0;
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_d = '0;
    tw_wr_en = 1'b0; tw_wr_addr = '0; tw_wr_data = '0;
    m_pos = 0;
    for (int i = 0; i < 512; i++) m_tw[i] = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check_lanes("reset outData", zero);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed values with unit twiddles
    load_tw(0);
    step(1'b1, 1'b1, pairs(32'd5, 32'd3), 1'b0, 0, '0);
    step(1'b1, 1'b0, pairs(32'd3, 32'd5), 1'b0, 0, '0);
    step(1'b1, 1'b0, pairs(Q - 32'd1, 32'd1), 1'b0, 0, '0);
    idle(4);

    // 2^16 * 2^16 reduces to 2^32 mod Q
    for (int unsigned k = 0; k < 16; k++) step(1'b0, 1'b0, '0, 1'b1, k, 32'd65536);
    step(1'b1, 1'b1, pairs(32'd0, 32'd65536), 1'b0, 0, '0);
    idle(4);

    // Two back-to-back frames exposing the table contents on even lanes
    load_tw(1);
    for (int i = 0; i < 64; i++) step(1'b1, (i == 0), pairs(32'd0, 32'd1), 1'b0, 0, '0);
    idle(4);

    // Random data and twiddles, gaps inside a frame
    load_tw(2);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, (i == 0), rand_lanes(), 1'b0, 0, '0);
      idle(int'($urandom_range(4, 1)));
    end
    // Resync at beat 10 abandons the partial frame
    for (int i = 0; i < 45; i++) step(1'b1, (i == 0 || i == 10), rand_lanes(), 1'b0, 0, '0);
    idle(4);

    // Same-cycle write to the row being read: old value must be used
    step(1'b1, 1'b1, rand_lanes(), 1'b1, 3, $urandom_range(32'hFFF00000, 0));
    step(1'b1, 1'b0, rand_lanes(), 1'b1, 16 + 5, $urandom_range(32'hFFF00000, 0));
    step(1'b1, 1'b0, rand_lanes(), 1'b0, 0, '0);
    idle(4);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_lanes(), 1'b0, 0, '0);
    rst = 1'b1;
    exp_q.delete();
    m_pos = 0;
    #1;
    check("mid-reset out_valid", 32'(out_valid), 32'd0);
    check_lanes("mid-reset outData", zero);
    @(negedge clk);
    check("mid-reset out_valid negedge", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 1'b0, rand_lanes(), 1'b0, 0, '0);
    idle(4);

    // Random traffic with concurrent table writes
    for (int i = 0; i < 300; i++)
      step(($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0), rand_lanes(),
           $urandom_range(1, 0) == 1, $urandom_range(511, 0), $urandom_range(32'hFFF00000, 0));
    idle(6);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
